multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller that turns the single-cycle datapath into a multicycle one: a shared instruction/data memory, an instruction register (IR), and ALU reuse for PC increment and branch target. It sits beside the datapath, reads the IR opcode, and drives every datapath mux and write enable state by state. Memory accesses stall on a `mem_ready` handshake. The controller supports R-type, addi, lw, sw, andi, beq, shift (opcode 110000) and j.

## Interface
Parameters:
- `OPW`, 6, opcode width

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]; valid from DECODE onward
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`, `pc_write_cond`  out  1  unconditional PC load / PC load if ALU zero
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1  memory strobes
- `ir_write`  out  1  IR load
- `reg_dst`, `mem_to_reg`, `reg_write`  out  1  register file write controls
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- `alu_op`  out  2  00 add, 01 sub/compare, 10 funct, 11 and
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state, for debug

## Operation
- State register is 4 bits. Next state is registered. Outputs are combinational from the state plus the `mem_ready` and opcode qualifiers listed below. Any output not listed for a state is 0.
- FETCH (0):
  - `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE (1):
  - `alu_src_a`=0, `alu_src_b`=11 (branch target into ALUOut).
  - Registers `opcode` into `op_q`.
  - Next state: 000000 or 110000 → EXEC; 100011 or 101011 → MEMADR; 001000 or 001100 → IEXEC; 000100 → BRANCH; 000010 → JUMP; any other opcode → TRAP.
- MEMADR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD if `op_q` is lw, else MEMWR.
- MEMRD (3): `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- MEMWR (5): `mem_write`=1, `i_or_d`=1, `instr_done`=`mem_ready`. Waits for `mem_ready`, then goes to FETCH.
- EXEC (6): `alu_src_a`=1, `alu_op`=10. `alu_src_b`=10 if `op_q`=110000, else 00. Goes to ALUWB.
- ALUWB (7): `reg_write`=1, `reg_dst`=1, `instr_done`=1. Goes to FETCH.
- IEXEC (8): `alu_src_a`=1, `alu_src_b`=10. `alu_op`=11 if `op_q` is andi, else 00. Goes to IWB.
- IWB (9): `reg_write`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- BRANCH (10): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_write_cond`=1, `instr_done`=1. Goes to FETCH.
- JUMP (11): `pc_src`=10, `pc_write`=1, `instr_done`=1. Goes to FETCH. j performs no register write.
- TRAP (12): `illegal_op`=1. Goes to FETCH; the PC has already advanced, so the instruction is skipped.
- Unused codes 13–15 go to FETCH with all outputs 0.

## Timing
- Reset:
  - While `reset_n`=0: state is FETCH, `op_q`=0, and every output is forced to 0, including FETCH's `mem_read`.
  - First FETCH activity occurs in the cycle after deassertion.
  - Reset asserted mid-instruction returns to FETCH asynchronously; no write enable may glitch high.
- Latency with zero wait states: beq, j and illegal take 3 cycles; R-type, shift, addi, andi and sw take 4; lw takes 5.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle. Strobes hold steady while waiting.
- `mem_ready` is ignored in every other state.
- `opcode` changes after DECODE are ignored; all later decisions use `op_q`.
- `instr_done` and `illegal_op` are never asserted together.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_ANDI, OP_BEQ, OP_SHIFT, OP_J)
  - the state enum
  - `alu_op`, `alu_src_b` and `pc_src` encodings
- One sub-module, `mc_opdecode`: a combinational opcode-to-next-state classifier used by DECODE.

## Test plan
- Reset release with `mem_ready`=1 and opcode 000000: states 0,1,6,7,0. `reg_write`=1 and `reg_dst`=1 only in ALUWB. `instr_done` pulses once.
- lw (100011) with `mem_ready` low for 2 cycles in MEMRD: 7 cycles total. `mem_read`=1 and `i_or_d`=1 are held throughout. `mem_to_reg`=1 in MEMWB.
- sw (101011) with `mem_ready`=0 for 3 cycles in FETCH: `pc_write`=0 and `ir_write`=0 until the ready cycle. `mem_write` is asserted only in MEMWR. `reg_write` stays 0.
- beq, then j: BRANCH shows `pc_write_cond`=1, `alu_op`=01, `pc_src`=01. JUMP shows `pc_src`=10, `pc_write`=1. Each takes 3 cycles.
- addi, then andi, then opcode 111111: `alu_op` is 00 then 11 in IEXEC. The unknown opcode gives an `illegal_op` pulse and a return to FETCH with no writes.
- `reset_n` pulsed low in MEMWR: all outputs go to 0 immediately, and the controller restarts in FETCH after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle sequencing controller: opcodes,
// FSM state encoding, datapath mux encodings and the control bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SHIFT = 6'b110000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_AND   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pc_src_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier: picks the state that follows DECODE.
module mc_opdecode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output state_e         next_state
);

  always_comb begin
    next_state = S_TRAP;
    case (opcode)
      OP_RTYPE, OP_SHIFT: next_state = S_EXEC;
      OP_LW, OP_SW:       next_state = S_MEMADR;
      OP_ADDI, OP_ANDI:   next_state = S_IEXEC;
      OP_BEQ:             next_state = S_BRANCH;
      OP_J:               next_state = S_JUMP;
      default:            next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath sequencer: walks fetch/decode/execute states and drives
// every datapath mux select and write enable, stalling on mem_ready.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     state
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  state_e         dec_next;
  ctrl_t          ctrl;
  ctrl_t          ctrl_gated;

  mc_opdecode #(.OPW(OPW)) u_opdecode (
    .opcode     (opcode),
    .next_state (dec_next)
  );

  // Next-state and opcode capture; op_q is frozen once DECODE is left.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = dec_next;
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Control decode per state; anything not set here stays 0.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.alu_src_b = (op_q == OP_SHIFT) ? SRCB_IMM : SRCB_REG;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op_q == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Outputs are held at 0 for the whole reset window, not just after the edge.
  assign ctrl_gated = reset_n ? ctrl : '0;

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign i_or_d        = ctrl_gated.i_or_d;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign ir_write      = ctrl_gated.ir_write;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_src        = ctrl_gated.pc_src;
  assign instr_done    = ctrl_gated.instr_done;
  assign illegal_op    = ctrl_gated.illegal_op;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-vector
// checks against hand-derived expected values for each instruction class.
module tb_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  // {pcw pcc iod mrd mwr irw, rdst m2r rw asa, asb, aop, psrc, done ill}
  logic [17:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, instr_done, illegal_op};

  localparam logic [17:0] V_ZERO   = 18'd0;
  localparam logic [17:0] V_FW     = {6'b000100, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_FR     = {6'b100101, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_DEC    = {6'b000000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_MADR   = {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_MRD    = {6'b001100, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_MWB    = {6'b000000, 4'b0110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] V_MWR_W  = {6'b001010, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_MWR_R  = {6'b001010, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] V_EXR    = {6'b000000, 4'b0001, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] V_EXS    = {6'b000000, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] V_ALUWB  = {6'b000000, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] V_IADD   = {6'b000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] V_IAND   = {6'b000000, 4'b0001, 2'b10, 2'b11, 2'b00, 2'b00};
  localparam logic [17:0] V_IWB    = {6'b000000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] V_BR     = {6'b010000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [17:0] V_JMP    = {6'b100000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [17:0] V_TRAP   = {6'b000000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01};

  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_LW = 6'b100011;
  localparam logic [5:0] O_SW = 6'b101011, O_ANDI = 6'b001100, O_BEQ = 6'b000100;
  localparam logic [5:0] O_SH = 6'b110000, O_J = 6'b000010, O_BAD = 6'b111111;

  multicycle_control #(.OPW(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: inputs set just after a rising edge, outputs checked 1ns later.
  task automatic test_reset();
    logic [3:0]  st [5];
    logic [17:0] ev [5];
    logic        rdy [5];
    int          dones;
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ev  = '{V_FR, V_DEC, V_EXR, V_ALUWB, V_FW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dones = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (state !== 4'd0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %0d expected 0", k, state);
      end
      n_vec++;
      if (obs !== V_ZERO) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got %b expected %b", k, obs, V_ZERO);
      end
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = O_R; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL rtype_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      if (instr_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL rtype_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [8];
    logic [17:0] ev [8];
    logic        rdy [8];
    logic [5:0]  op [8];
    st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    ev  = '{V_FR, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MWB, V_FW};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op  = '{O_LW, O_LW, O_SW, O_SW, O_SW, O_SW, O_SW, O_SW};
    for (int i = 0; i < 8; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_fetch_wait();
    logic [3:0]  st [9];
    logic [17:0] ev [9];
    logic        rdy [9];
    logic [5:0]  op [9];
    st  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    ev  = '{V_FW, V_FW, V_FW, V_FR, V_DEC, V_MADR, V_MWR_W, V_MWR_R, V_FW};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    op  = '{O_SW, O_SW, O_SW, O_SW, O_SW, O_LW, O_LW, O_LW, O_LW};
    for (int i = 0; i < 9; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL sw_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0]  st [7];
    logic [17:0] ev [7];
    logic        rdy [7];
    logic [5:0]  op [7];
    st  = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd11, 4'd0};
    ev  = '{V_FR, V_DEC, V_BR, V_FR, V_DEC, V_JMP, V_FW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    op  = '{O_BEQ, O_BEQ, O_BEQ, O_J, O_J, O_J, O_J};
    for (int i = 0; i < 7; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL brj_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL brj_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm_illegal();
    logic [3:0]  st [12];
    logic [17:0] ev [12];
    logic        rdy [12];
    logic [5:0]  op [12];
    st  = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0, 4'd1, 4'd8, 4'd9, 4'd0, 4'd1, 4'd12, 4'd0};
    ev  = '{V_FR, V_DEC, V_IADD, V_IWB, V_FR, V_DEC, V_IAND, V_IWB,
            V_FR, V_DEC, V_TRAP, V_FW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b0};
    op  = '{O_ADDI, O_ADDI, O_ANDI, O_ANDI, O_ANDI, O_ANDI, O_ADDI, O_ADDI,
            O_BAD, O_BAD, O_BAD, O_BAD};
    for (int i = 0; i < 12; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL imm_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL imm_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift();
    logic [3:0]  st [5];
    logic [17:0] ev [5];
    logic        rdy [5];
    logic [5:0]  op [5];
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ev  = '{V_FR, V_DEC, V_EXS, V_ALUWB, V_FW};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    op  = '{O_SH, O_SH, O_R, O_R, O_R};
    for (int i = 0; i < 5; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL shift_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL shift_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  st [5];
    logic [17:0] ev [5];
    logic        rdy [5];
    st  = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0};
    ev  = '{V_FR, V_DEC, V_MADR, V_ZERO, V_ZERO};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      opcode = O_SW; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL midrst_pre_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL midrst_pre_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd5 || obs !== V_MWR_W) begin
      n_err++;
      $display("FAIL midrst_memwr: got state %0d ctrl %b expected 5 %b", state, obs, V_MWR_W);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || obs !== V_ZERO) begin
      n_err++;
      $display("FAIL midrst_async: got state %0d ctrl %b expected 0 %b", state, obs, V_ZERO);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (state !== 4'd0 || obs !== V_ZERO) begin
      n_err++;
      $display("FAIL midrst_held: got state %0d ctrl %b expected 0 %b", state, obs, V_ZERO);
    end
    reset_n = 1'b1;
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ev  = '{V_FR, V_DEC, V_EXR, V_ALUWB, V_FW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      opcode = O_R; mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== st[i]) begin
        n_err++;
        $display("FAIL midrst_post_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_vec++;
      if (obs !== ev[i]) begin
        n_err++;
        $display("FAIL midrst_post_ctrl[%0d]: got %b expected %b", i, obs, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    @(posedge clk); #1;
    test_reset();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch_jump();
    test_imm_illegal();
    test_shift();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
